// File: rtl/pcnt_cfg_pkg.sv
// Shared definitions for the counter configuration path: CSR map, data widths,
// direction encodings and the arbiter state type.
package pcnt_cfg_pkg;

    localparam int CFG_AW = 3;
    localparam int CFG_DW = 10;

    localparam logic [CFG_AW-1:0] CSR_DIR  = 3'd0;
    localparam logic [CFG_AW-1:0] CSR_MIN  = 3'd1;
    localparam logic [CFG_AW-1:0] CSR_MAX  = 3'd2;
    localparam logic [CFG_AW-1:0] CSR_STEP = 3'd3;

    typedef enum logic [1:0] {
        DIR_UP      = 2'd0,
        DIR_DOWN    = 2'd1,
        DIR_SUSPEND = 2'd2
    } pcnt_dir_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    // Decoded CSR space ends at CSR_STEP; anything above is unmapped.
    function automatic logic csr_addr_unmapped(input logic [CFG_AW-1:0] addr);
        return (addr > CSR_STEP);
    endfunction

endpackage

// File: rtl/pcnt_cfg_arb_rr.sv
// Combinational round-robin picker: searches ptr+1 .. ptr+N (mod N) and
// returns the first requester found as a one-hot grant plus its index.
module pcnt_rr_arb #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    int            cand;
    logic [IW-1:0] cand_idx;
    logic          hit;

    // Walk the rotated request vector, keeping only the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        hit       = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand      = (int'(ptr) + k) % N;
            cand_idx  = IW'(cand);
            hit       = req[cand_idx] & ~grant_any;
            grant     = grant | ({{(N-1){1'b0}}, hit} << cand);
            grant_idx = hit ? cand_idx : grant_idx;
            grant_any = grant_any | hit;
        end
    end

endmodule

// File: rtl/pcnt_cfg_arb.sv
// Round-robin arbiter serialising NUM_REQ requesters onto the counter's config port.
// Optional feature macro: PCNT_CFG_ARB_ADDR_CHECK_EN (reject addresses above CSR_STEP).
module pcnt_cfg_arb
    import pcnt_cfg_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int AW      = CFG_AW,
    parameter int DW      = CFG_DW,
    parameter int RD_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_rd_wr,
    input  logic [NUM_REQ*AW-1:0]      req_addr,
    input  logic [NUM_REQ*DW-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DW-1:0]              rsp_rdata,
    output logic                       rsp_err,
    output logic                       cfg_enable,
    output logic                       cfg_rd_wr,
    output logic [AW-1:0]              cfg_addr,
    output logic [DW-1:0]              cfg_wdata,
    input  logic [DW-1:0]              cfg_rdata,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = 3;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          cfg_enable_q, cfg_enable_d;
    logic          cfg_rd_wr_q, cfg_rd_wr_d;
    logic [AW-1:0] cfg_addr_q, cfg_addr_d;
    logic [DW-1:0] cfg_wdata_q, cfg_wdata_d;

    logic [NUM_REQ-1:0] gnt_vec;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               sel_rd_wr;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic               addr_bad;

    pcnt_rr_arb #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (gnt_vec),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    assign sel_rd_wr = req_rd_wr[gnt_idx];
    assign sel_addr  = req_addr[gnt_idx*AW +: AW];
    assign sel_wdata = req_wdata[gnt_idx*DW +: DW];

`ifdef PCNT_CFG_ARB_ADDR_CHECK_EN
    assign addr_bad = (sel_addr > AW'(CSR_STEP));
`else
    assign addr_bad = 1'b0;
`endif

    // Next-state, handshake and captured-transaction logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cfg_enable_d = 1'b0;
        cfg_rd_wr_d  = cfg_rd_wr_q;
        cfg_addr_d   = cfg_addr_q;
        cfg_wdata_d  = cfg_wdata_q;
        req_ready    = '0;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_any) begin
                    req_ready = gnt_vec;
                    ptr_d     = gnt_idx;
                    id_d      = gnt_idx;
                    rdata_d   = '0;
                    err_d     = addr_bad;
                    // Rejected addresses never reach the counter; cfg_* keep their old values.
                    if (addr_bad) begin
                        state_d = ARB_RESP;
                    end else begin
                        state_d      = ARB_ISSUE;
                        cfg_enable_d = 1'b1;
                        cfg_rd_wr_d  = sel_rd_wr;
                        cfg_addr_d   = sel_addr;
                        cfg_wdata_d  = sel_wdata;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (cfg_rd_wr_q) begin
                    state_d = ARB_WAIT;
                    cnt_d   = CW'(RD_LAT - 1);
                end else begin
                    state_d = ARB_RESP;
                end
            end
            ARB_WAIT: begin
                if (cnt_q == {CW{1'b0}}) begin
                    rdata_d = cfg_rdata;
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            ptr_q        <= IW'(NUM_REQ - 1);
            id_q         <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cfg_enable_q <= 1'b0;
            cfg_rd_wr_q  <= 1'b0;
            cfg_addr_q   <= '0;
            cfg_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cfg_enable_q <= cfg_enable_d;
            cfg_rd_wr_q  <= cfg_rd_wr_d;
            cfg_addr_q   <= cfg_addr_d;
            cfg_wdata_q  <= cfg_wdata_d;
        end
    end

    // Response outputs are decoded purely from registered state.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (state_q == ARB_RESP) begin
            rsp_valid = {{(NUM_REQ-1){1'b0}}, 1'b1} << id_q;
            rsp_rdata = rdata_q;
            rsp_err   = err_q;
        end else begin
            rsp_valid = '0;
        end
    end

    assign busy       = (state_q != ARB_IDLE);
    assign grant_id   = id_q;
    assign cfg_enable = cfg_enable_q;
    assign cfg_rd_wr  = cfg_rd_wr_q;
    assign cfg_addr   = cfg_addr_q;
    assign cfg_wdata  = cfg_wdata_q;

endmodule
